id_stage_hz: RTL



---
 rtl/id_stage_hz_if.sv | 58 +++++
 rtl/id_stage_hz.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz_if.sv
// ID-stage bundle: IF handshake, register-file read ports, WB/MEM
// hazard inputs, ID/EX register outputs and branch redirect.
interface id_stage_hz_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 9
);
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_pc4;
  logic [31:0]       if_inst;
  logic [RA_W-1:0]   rf_raddr1;
  logic [RA_W-1:0]   rf_raddr2;
  logic [XLEN-1:0]   rf_rdata1;
  logic [XLEN-1:0]   rf_rdata2;
  logic              wb_we;
  logic [RA_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              mem_we;
  logic [RA_W-1:0]   mem_rd;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [RA_W-1:0]   ex_rd;
  logic [XLEN-1:0]   ex_pc4;
  logic              ex_illegal;
  logic              br_taken;
  logic [XLEN-1:0]   br_target;

  modport slave (
    input  if_valid, if_pc, if_pc4, if_inst,
    input  rf_rdata1, rf_rdata2,
    input  wb_we, wb_rd, wb_data,
    input  mem_we, mem_rd, flush, ex_ready,
    output if_ready, rf_raddr1, rf_raddr2,
    output ex_valid, ex_ctrl, ex_rs1_data,
    output ex_rs2_data, ex_imm, ex_rd,
    output ex_pc4, ex_illegal,
    output br_taken, br_target
  );

  modport master (
    output if_valid, if_pc, if_pc4, if_inst,
    output rf_rdata1, rf_rdata2,
    output wb_we, wb_rd, wb_data,
    output mem_we, mem_rd, flush, ex_ready,
    input  if_ready, rf_raddr1, rf_raddr2,
    input  ex_valid, ex_ctrl, ex_rs1_data,
    input  ex_rs2_data, ex_imm, ex_rd,
    input  ex_pc4, ex_illegal,
    input  br_taken, br_target
  );
endinterface

// File: rtl/id_stage_hz.sv
// RV32 decode stage: decode, RF read with WB bypass, branch resolve,
// load-use / branch-operand stalls, redirect shadow, ID/EX register.
// Ports: clk, reset_n (sync, active-low), bus (id_stage_hz_if.slave).
// Macro ID_EXT_BRANCH_EN adds BNE/BLT/BGE; otherwise only BEQ.
module id_stage_hz #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 9
) (
  input logic          clk,
  input logic          reset_n,
  id_stage_hz_if.slave bus
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t state_q, state_d;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign inst = bus.if_inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign rd   = inst[11:7];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic op_imm, op_ld, op_st, op_jal, op_jalr, op_br, op_r;
  assign op_imm  = opc == 7'b0010011;
  assign op_ld   = opc == 7'b0000011;
  assign op_st   = opc == 7'b0100011;
  assign op_jal  = opc == 7'b1101111;
  assign op_jalr = opc == 7'b1100111;
  assign op_br   = opc == 7'b1100011;
  assign op_r    = opc == 7'b0110011;

  logic [XLEN-1:0] op1, op2;
  assign op1 = (rs1 == '0) ? '0 :
               (bus.wb_we && bus.wb_rd == rs1) ? bus.wb_data :
               bus.rf_rdata1;
  assign op2 = (rs2 == '0) ? '0 :
               (bus.wb_we && bus.wb_rd == rs2) ? bus.wb_data :
               bus.rf_rdata2;
  assign bus.rf_raddr1 = rs1;
  assign bus.rf_raddr2 = rs2;

  logic            eq;
  assign eq = op1 == op2;
`ifdef ID_EXT_BRANCH_EN
  logic            lt;
  assign lt = $signed(op1) < $signed(op2);
`endif

  logic [8:0]      c9;
  logic [2:0]      aop;
  logic            ill, use1, use2, wr;
  logic            is_br, is_jal, is_jalr, cond, br_ok, r_ok;
  logic [XLEN-1:0] imm;

  always_comb begin
    c9      = '0;
    aop     = 3'b000;
    ill     = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    wr      = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    imm     = '0;
    r_ok    = 1'b1;
`ifdef ID_EXT_BRANCH_EN
    br_ok = f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
    case (f3)
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      default: cond = eq;
    endcase
`else
    br_ok = f3 == 3'b000;
    cond  = eq;
`endif
    if (f7 == 7'b0000000) begin
      case (f3)
        3'b000:  aop = 3'b000;
        3'b001:  aop = 3'b100;
        3'b010:  aop = 3'b101;
        3'b110:  aop = 3'b011;
        3'b111:  aop = 3'b010;
        default: r_ok = 1'b0;
      endcase
    end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
      aop = 3'b001;
    end else begin
      r_ok = 1'b0;
    end
    unique case (1'b1)
      op_imm: begin
        ill = f3 != 3'b000;
        c9  = 9'b00_1_00_000_1;
        use1 = 1'b1; wr = 1'b1; imm = imm_i;
      end
      op_ld: begin
        ill = f3 != 3'b010;
        c9  = 9'b01_1_10_000_1;
        use1 = 1'b1; wr = 1'b1; imm = imm_i;
      end
      op_st: begin
        ill = f3 != 3'b010;
        c9  = 9'b00_0_01_000_1;
        use1 = 1'b1; use2 = 1'b1; imm = imm_s;
      end
      op_jal: begin
        c9  = 9'b10_1_00_000_0;
        wr = 1'b1; is_jal = 1'b1; imm = imm_j;
      end
      op_jalr: begin
        ill = f3 != 3'b000;
        c9  = 9'b10_1_00_000_0;
        use1 = 1'b1; wr = 1'b1;
        is_jalr = 1'b1; imm = imm_i;
      end
      op_br: begin
        ill = !br_ok;
        use1 = 1'b1; use2 = 1'b1;
        is_br = 1'b1; imm = imm_b;
      end
      op_r: begin
        ill = !r_ok;
        c9  = {2'b00, 1'b1, 2'b00, aop, 1'b0};
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings travel as an inert, non-redirecting entry.
    if (ill) begin
      c9 = '0; use1 = 1'b0; use2 = 1'b0; wr = 1'b0;
      is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    end
    if (rd == '0) c9[6] = 1'b0;
  end

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [XLEN-1:0]   ex_rs1_q, ex_rs2_q, ex_imm_q, ex_pc4_q;
  logic [RA_W-1:0]   ex_rd_q;
  logic              ex_ill_q;

  logic ex_hit, mem_hit, lu, bh, hz, taken, issue, rdy;

  assign ex_hit  = ex_rd_q != '0 &&
                   ((use1 && rs1 == ex_rd_q) || (use2 && rs2 == ex_rd_q));
  assign mem_hit = bus.mem_we && bus.mem_rd != '0 &&
                   ((use1 && rs1 == bus.mem_rd) ||
                    (use2 && rs2 == bus.mem_rd));
  assign lu = ex_valid_q && ex_ctrl_q[5] && ex_hit;
  // Branches resolve here, so any in-flight producer must retire first.
  assign bh = (is_br || is_jalr) &&
              ((ex_valid_q && ex_ctrl_q[6] && ex_hit) || mem_hit);
  assign hz = bus.if_valid && (lu || bh);
  assign taken = is_jal || is_jalr || (is_br && cond);

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    issue   = 1'b0;
    if (bus.flush) begin
      rdy     = 1'b1;
      state_d = RUN;
    end else if (bus.ex_ready) begin
      if (state_q == SHADOW) begin
        rdy = 1'b1;
        if (bus.if_valid) state_d = RUN;
      end else begin
        rdy   = !hz;
        issue = bus.if_valid && !hz;
        if (issue && taken) state_d = SHADOW;
      end
    end
  end

  logic [CTRL_W-1:0] ctrl_d;
  always_comb begin
    ctrl_d      = '0;
    ctrl_d[8:0] = c9;
  end

  assign bus.if_ready  = rdy;
  assign bus.br_taken  = issue && taken;
  assign bus.br_target = is_jalr ? ((op1 + imm) & ~XLEN'(1)) :
                         (bus.if_pc + imm);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_pc4_q   <= '0;
      ex_ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (bus.ex_ready) begin
        ex_valid_q <= issue;
        if (issue) begin
          ex_ctrl_q <= ctrl_d;
          ex_rs1_q  <= op1;
          ex_rs2_q  <= op2;
          ex_imm_q  <= imm;
          ex_rd_q   <= wr ? rd : '0;
          ex_pc4_q  <= bus.if_pc4;
          ex_ill_q  <= ill;
        end
      end
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_rs1_data = ex_rs1_q;
  assign bus.ex_rs2_data = ex_rs2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_pc4      = ex_pc4_q;
  assign bus.ex_illegal  = ex_ill_q;

endmodule
